// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the data memory between the core LSU and DMA.
// One command is latched per grant, drives memory for one cycle, then responds.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [2:0]            core_funct3,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_err,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [2:0]            dma_funct3,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_err,

    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  err_sticky
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("dmem_port_arbiter: DATA_WIDTH must be 32");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_last_owner;
    logic                  r_owner;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_err_sticky;

    logic w_idle;
    logic w_any;
    logic w_pick_dma;
    logic w_legal;

    assign w_idle = (r_state == S_IDLE);
    assign w_any  = core_req | dma_req;

    // Owner encoding: 1 = DMA. On a tie the requester that did not win last time gets it.
    assign w_pick_dma = dma_req & (~core_req | ~r_last_owner);

    assign core_gnt = w_idle & core_req & ~w_pick_dma;
    assign dma_gnt  = w_idle & w_pick_dma;

    always_comb begin
        w_legal = 1'b0;
        case (r_funct3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~r_addr[0];
            3'b010:  w_legal = (r_addr[1:0] == 2'b00);
            3'b100:  w_legal = ~r_we;
            3'b101:  w_legal = ~r_we & ~r_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner      <= w_pick_dma;
                        r_last_owner <= w_pick_dma;
                        r_we         <= w_pick_dma ? dma_we     : core_we;
                        r_funct3     <= w_pick_dma ? dma_funct3 : core_funct3;
                        r_addr       <= w_pick_dma ? dma_addr   : core_addr;
                        r_wdata      <= w_pick_dma ? dma_wdata  : core_wdata;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rdata <= (w_legal & ~r_we) ? mem_rdata : '0;
                    r_err   <= ~w_legal;
                    if (!w_legal) begin
                        r_err_sticky <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded from the state register, so an async reset kills the write at once.
    assign mem_wr_en  = (r_state == S_ACCESS) & r_we & w_legal;
    assign mem_funct3 = r_funct3;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

    assign core_rvalid = (r_state == S_RESP) & ~r_owner;
    assign dma_rvalid  = (r_state == S_RESP) & r_owner;
    assign core_rdata  = r_rdata;
    assign dma_rdata   = r_rdata;
    assign core_err    = r_err;
    assign dma_err     = r_err;
    assign err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-addressed memory model.
// Table of single transactions, then reset-in-ACCESS and tie arbitration.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_gnt, core_rvalid, core_err;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid, dma_err;
    logic [2:0]  dma_funct3;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err_sticky;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_funct3(dma_funct3),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_sticky(err_sticky)
    );

    // Memory model: combinational sized read, synchronous sized write.
    logic [7:0] mem [0:255];
    logic [7:0] ma;

    always_comb begin
        ma = mem_addr[7:0];
        mem_rdata = '0;
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
            3'b100:  mem_rdata = {24'h0, mem[ma]};
            3'b001:  mem_rdata = {{16{mem[ma+8'd1][7]}}, mem[ma+8'd1], mem[ma]};
            3'b101:  mem_rdata = {16'h0, mem[ma+8'd1], mem[ma]};
            3'b010:  mem_rdata = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
            default: mem_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00)
                mem[mem_addr[7:0]+8'd1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_addr[7:0]+8'd2] <= mem_wdata[23:16];
                mem[mem_addr[7:0]+8'd3] <= mem_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic        who;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic who, input logic req, input logic we,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        if (!who) begin
            core_req = req; core_we = we; core_funct3 = f3;
            core_addr = a; core_wdata = d;
        end else begin
            dma_req = req; dma_we = we; dma_funct3 = f3;
            dma_addr = a; dma_wdata = d;
        end
    endtask

    task automatic txn(input vec_t v, input int idx);
        bit   got;
        logic g;
        got = 0;
        @(negedge clk);
        drive(v.who, 1'b1, v.we, v.f3, v.addr, v.wdata);
        for (int n = 0; n < 8 && !got; n++) begin
            #1;
            g = v.who ? dma_gnt : core_gnt;
            if (g) got = 1;
            else @(negedge clk);
        end
        chk($sformatf("v%0d_gnt", idx), {31'b0, got}, 32'd1);
        if (!got) begin
            drive(v.who, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
            return;
        end
        chk($sformatf("v%0d_other_gnt", idx), {31'b0, v.who ? core_gnt : dma_gnt}, 32'd0);
        chk($sformatf("v%0d_wr_idle", idx), {31'b0, mem_wr_en}, 32'd0);
        @(posedge clk); #1;
        drive(v.who, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        chk($sformatf("v%0d_wr_access", idx), {31'b0, mem_wr_en}, {31'b0, v.we & ~v.exp_err});
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
        chk($sformatf("v%0d_no_early_rv", idx), {31'b0, core_rvalid | dma_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_wr_resp", idx), {31'b0, mem_wr_en}, 32'd0);
        chk($sformatf("v%0d_rvalid", idx), {31'b0, v.who ? dma_rvalid : core_rvalid}, 32'd1);
        chk($sformatf("v%0d_other_rv", idx), {31'b0, v.who ? core_rvalid : dma_rvalid}, 32'd0);
        chk($sformatf("v%0d_rdata", idx), v.who ? dma_rdata : core_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), {31'b0, v.who ? dma_err : core_err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d_sticky", idx), {31'b0, err_sticky}, {31'b0, v.exp_sticky});
        @(posedge clk); #1;
        chk($sformatf("v%0d_rv_drop", idx), {31'b0, core_rvalid | dma_rvalid}, 32'd0);
    endtask

    int gcyc[4];
    int gwho[4];
    int ng, nrc, nrd;

    initial begin
        //            who we  f3      addr       wdata         rdata         err sticky
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h13, 32'h0,        32'h00000000, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h12, 32'hCAFEF00D, 32'h00000000, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h00000000, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h21, 32'h000000A5, 32'h00000000, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 3'b100, 32'h21, 32'h0,        32'h000000A5, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 3'b000, 32'h21, 32'h0,        32'hFFFFFFA5, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h20, 32'h0,        32'h00000000, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h20, 32'h00000000, 32'h00000000, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'h1122A544, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h00000000, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 3'b101, 32'h22, 32'h0,        32'h0000BEEF, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 3'b010, 32'h20, 32'h0,        32'hBEEFA544, 1'b0, 1'b1};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_gnt", {30'b0, core_gnt, dma_gnt}, 32'd0);
        chk("rst_rvalid", {30'b0, core_rvalid, dma_rvalid}, 32'd0);
        chk("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_funct3", {29'b0, mem_funct3}, 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_err", {30'b0, core_err, dma_err}, 32'd0);
        chk("rst_sticky", {31'b0, err_sticky}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) txn(vecs[i], i);

        // Reset arriving while a core store is in ACCESS.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h55555555);
        #1;
        chk("rstmid_gnt", {31'b0, core_gnt}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        chk("rstmid_wr_before", {31'b0, mem_wr_en}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rstmid_wr_after", {31'b0, mem_wr_en}, 32'd0);
        chk("rstmid_sticky", {31'b0, err_sticky}, 32'd0);
        chk("rstmid_rvalid", {31'b0, core_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("rstmid_rvalid2", {31'b0, core_rvalid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("rstmid_no_rv", {30'b0, core_rvalid, dma_rvalid}, 32'd0);
        end

        // Both requesting after reset: core first, then alternate every 3 cycles.
        for (int k = 0; k < 4; k++) begin
            gcyc[k] = -1;
            gwho[k] = -1;
        end
        ng = 0; nrc = 0; nrd = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        for (int c = 0; c < 16; c++) begin
            if (ng >= 4) begin
                drive(1'b0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
                drive(1'b1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
            end
            #1;
            if (core_gnt && dma_gnt)
                chk("tie_double_gnt", 32'd1, 32'd0);
            if (core_gnt || dma_gnt) begin
                if (ng < 4) begin
                    gcyc[ng] = c;
                    gwho[ng] = dma_gnt ? 1 : 0;
                end
                ng++;
            end
            if (core_rvalid) begin
                nrc++;
                chk("tie_core_rv_slot",
                    {31'b0, (ng > 0 && ng <= 4 && gwho[ng-1] == 0 && gcyc[ng-1] == c - 2)}, 32'd1);
                chk("tie_core_rdata", core_rdata, 32'hDEADBEEF);
                chk("tie_core_rv_excl", {31'b0, dma_rvalid}, 32'd0);
            end
            if (dma_rvalid) begin
                nrd++;
                chk("tie_dma_rv_slot",
                    {31'b0, (ng > 0 && ng <= 4 && gwho[ng-1] == 1 && gcyc[ng-1] == c - 2)}, 32'd1);
                chk("tie_dma_rdata", dma_rdata, 32'hBEEFA544);
            end
            @(negedge clk);
        end
        chk("tie_ngrants", ng, 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tie_who%0d", k), gwho[k], k % 2);
            chk($sformatf("tie_cyc%0d", k), gcyc[k], 3 * k);
        end
        chk("tie_core_rv_cnt", nrc, 32'd2);
        chk("tie_dma_rv_cnt", nrd, 32'd2);
        chk("tie_sticky", {31'b0, err_sticky}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported data memory (combinational read, synchronous byte/half/word write selected by funct3) between the core load/store unit and a DMA/debug requester.
- Arbitrates round-robin, latches one command, and drives the memory for exactly one cycle.
- Returns a registered response, rejecting misaligned or illegal accesses before they reach the memory.
- Sits between the LSU/DMA and the data memory instance.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width; must be 32, because the alignment rules assume 4-byte words

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core request; held with its fields until core_gnt
- core_we  in  1  1=store, 0=load
- core_funct3  in  3  RISC-V load/store funct3
- core_addr  in  ADDR_WIDTH  byte address
- core_wdata  in  DATA_WIDTH  store data
- core_gnt  out  1  request accepted this cycle
- core_rvalid  out  1  response pulse
- core_rdata  out  DATA_WIDTH  load data, valid with core_rvalid
- core_err  out  1  access rejected, valid with core_rvalid
- dma_req, dma_we, dma_funct3, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, dma_err: same widths and meaning as the core_* ports, for the DMA requester
- mem_wr_en  out  1  memory write enable
- mem_funct3  out  3  memory access type
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data (combinational from mem_addr/mem_funct3)
- err_sticky  out  1  set on any rejected access; cleared only by reset

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state: FSM=IDLE; last_owner=DMA; command register, response register, mem_* outputs, rdata, err, err_sticky all 0; all gnt/rvalid outputs 0. mem_wr_en drops immediately on reset assertion.
- FSM states:
  - IDLE: if any req, pick a winner, assert its gnt combinationally this cycle, latch owner/we/funct3/addr/wdata into the command register, go to ACCESS. With no req, stay in IDLE.
  - ACCESS (one cycle): mem_funct3/mem_addr/mem_wdata come from the command register. mem_wr_en = cmd_we & legal. At the clock edge, capture mem_rdata (load) or 0 (store or illegal) and the err flag. Go to RESP.
  - RESP (one cycle): assert the owner's rvalid with rdata and err; the other requester's rvalid stays 0. Go to IDLE.
- Latency: gnt in cycle N, memory access in N+1, rvalid in N+2. Next gnt no earlier than N+3.
- gnt is asserted only in IDLE; a req in ACCESS or RESP waits.
- Arbitration:
  - Only one requesting: it wins.
  - Both requesting: the one that is not last_owner wins. last_owner updates at each grant.
  - The first tie after reset goes to core.
- Legality, evaluated on the latched command:
  - Legal loads: funct3 000/100 (any address); 001/101 with addr[0]=0; 010 with addr[1:0]=00.
  - Legal stores: funct3 000 (any address); 001 with addr[0]=0; 010 with addr[1:0]=00.
  - Anything else is illegal: misaligned, funct3 011/110/111, or a store with 100/101.
  - Illegal access: mem_wr_en stays 0, rdata=0, err=1, err_sticky set.
- mem_wr_en is 1 only in ACCESS. mem_funct3/mem_addr/mem_wdata hold the command register value in all states.
- rdata/err hold their last value outside rvalid; consumers sample them only on rvalid.
- Requester behaviour: req may drop in the cycle after gnt. A req dropped before gnt is simply never served; there is no cancel of a granted command.
- Reset during ACCESS or RESP: the command and response are discarded, no rvalid is issued, and a write in progress at the reset edge is not performed.

Test Plan:
- Core sw addr 0x10, funct3 010, wdata 0xDEADBEEF, then core lw 0x10 → core_gnt at N, mem_wr_en=1 only in N+1, core_rvalid at N+2 with err=0; the load returns 0xDEADBEEF.
- Core and dma req together, both held for 4 transactions → grants alternate core, dma, core, dma; gnt spacing is 3 cycles; each rvalid goes only to its owner.
- dma lh funct3 001 at addr 0x13; core sw funct3 010 at addr 0x12 → each gives err=1, rdata=0, mem_wr_en never 1, err_sticky=1.
- Core sb 0xA5 at 0x21 after sw 0x11223344 at 0x20, then lbu 0x21 and lb 0x21 → loads return 0x000000A5 and 0xFFFFFFA5.
- Illegal funct3 011 load, and store with funct3 100 → err=1, no write; a following sw/lw at the same address proves memory unchanged.
- reset asserted mid-ACCESS of a core sw → mem_wr_en falls immediately, no rvalid, FSM IDLE, err_sticky=0; a read-back shows the old data.
